// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decoded control bundles through DEPTH stages, one cycle per stage, with a valid bit per stage.
// Backpressure: per-stage stall/flush; holds propagate back to decode (stallD), bubbles go forward; stage 0 holds for multi-cycle ops.
module ctrl_pipe #(
   parameter int CTRLW = 13,
   parameter int DEPTH = 3,
   parameter int CNTW  = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CTRLW-1:0]       ctrlD,
   input  logic                   validD,
   input  logic                   mcD,
   input  logic [CNTW-1:0]        mclenD,
   input  logic [DEPTH-1:0]       stall,
   input  logic [DEPTH-1:0]       flush,
   output logic [DEPTH*CTRLW-1:0] ctrl_flat,
   output logic [DEPTH-1:0]       valid,
   output logic                   stallD,
   output logic                   mc_busy,
   output logic                   mc_done
);

   logic [CTRLW-1:0] ctrl_q [DEPTH];
   logic [CTRLW-1:0] ctrl_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [DEPTH-1:0] hold;
   logic             mcwait;
   logic             load0;

   // Hold ripples from the last stage back towards decode.
   always_comb begin
      logic h;
      mcwait = (cnt_q > CNTW'(1));
      hold   = '0;
      h      = stall[DEPTH-1];
      hold[DEPTH-1] = h;
      for (int k = DEPTH - 2; k >= 1; k--) begin
         h       = stall[k] | h;
         hold[k] = h;
      end
      hold[0] = stall[0] | hold[1] | mcwait;
   end

   assign load0 = ~flush[0] & ~hold[0];

   always_comb begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;

      if (flush[0]) begin
         ctrl_d[0]  = '0;
         valid_d[0] = 1'b0;
      end else if (!hold[0]) begin
         ctrl_d[0]  = ctrlD;
         valid_d[0] = validD;
      end

      for (int k = 1; k < DEPTH; k++) begin
         if (flush[k]) begin
            ctrl_d[k]  = '0;
            valid_d[k] = 1'b0;
         end else if (hold[k]) begin
            ctrl_d[k]  = ctrl_q[k];
            valid_d[k] = valid_q[k];
         end else if (hold[k-1]) begin
            ctrl_d[k]  = '0;
            valid_d[k] = 1'b0;
         end else begin
            ctrl_d[k]  = ctrl_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
      end
   end

   // Lengths 0 and 1 load as 0 so the op behaves as single-cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (flush[0]) begin
         cnt_d = '0;
      end else if (load0 && validD && mcD) begin
         cnt_d = (mclenD > CNTW'(1)) ? mclenD : '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q  <= '{default: '0};
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ctrl_flat = '0;
      for (int k = 0; k < DEPTH; k++) begin
         ctrl_flat[k*CTRLW +: CTRLW] = ctrl_q[k];
      end
   end

   assign valid   = valid_q;
   assign stallD  = hold[0];
   assign mc_busy = (cnt_q != '0);
   assign mc_done = (cnt_q == CNTW'(1));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed vector bench for ctrl_pipe (defaults CTRLW=13, DEPTH=3, CNTW=6).
module tb_ctrl_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] ctrlD;
   logic        validD;
   logic        mcD;
   logic [5:0]  mclenD;
   logic [2:0]  stall;
   logic [2:0]  flush;
   logic [38:0] ctrl_flat;
   logic [2:0]  valid;
   logic        stallD;
   logic        mc_busy;
   logic        mc_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ctrl_pipe #(.CTRLW(13), .DEPTH(3), .CNTW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctrlD     (ctrlD),
      .validD    (validD),
      .mcD       (mcD),
      .mclenD    (mclenD),
      .stall     (stall),
      .flush     (flush),
      .ctrl_flat (ctrl_flat),
      .valid     (valid),
      .stallD    (stallD),
      .mc_busy   (mc_busy),
      .mc_done   (mc_done)
   );

   // Inputs applied in a cycle, and outputs expected during that same cycle.
   typedef struct {
      logic        rst;
      logic [12:0] ctrl;
      logic        vld;
      logic        mc;
      logic [5:0]  len;
      logic [2:0]  stall;
      logic [2:0]  flush;
      logic [12:0] e, m, w;
      logic [2:0]  valid;
      logic        stalld, busy, done;
   } vec_t;

   function automatic vec_t mk(input int r, input int c, input int v, input int mc, input int len,
                               input int st, input int fl, input int e, input int m, input int w,
                               input int vl, input int sd, input int bz, input int dn);
      vec_t x;
      x.rst = 1'(r);     x.ctrl = 13'(c);   x.vld = 1'(v);     x.mc = 1'(mc);
      x.len = 6'(len);   x.stall = 3'(st);  x.flush = 3'(fl);
      x.e = 13'(e);      x.m = 13'(m);      x.w = 13'(w);      x.valid = 3'(vl);
      x.stalld = 1'(sd); x.busy = 1'(bz);   x.done = 1'(dn);
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_row(input string tag, input vec_t v);
      rst = v.rst; ctrlD = v.ctrl; validD = v.vld; mcD = v.mc; mclenD = v.len;
      stall = v.stall; flush = v.flush;
      @(negedge clk);
      chk({tag, " ctrl_flat"}, 64'(ctrl_flat), 64'({v.w, v.m, v.e}));
      chk({tag, " valid"},     64'(valid),     64'(v.valid));
      chk({tag, " stallD"},    64'(stallD),    64'(v.stalld));
      chk({tag, " mc_busy"},   64'(mc_busy),   64'(v.busy));
      chk({tag, " mc_done"},   64'(mc_done),   64'(v.done));
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [30];
   vec_t seq [10];

   initial begin
      //             rst ctrl    v mc len st  fl  E      M      W      vld sD bz dn
      // reset, then A5..A8 streaming
      tbl[0]  = mk(1, 'h000,  0, 0, 0,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[1]  = mk(1, 'h1FFF, 1, 1, 5,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[2]  = mk(0, 'h0A5,  1, 0, 0,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[3]  = mk(0, 'h0A6,  1, 0, 0,  0,  0,  'h0A5, 'h000, 'h000, 1,  0, 0, 0);
      tbl[4]  = mk(0, 'h0A7,  1, 0, 0,  0,  0,  'h0A6, 'h0A5, 'h000, 3,  0, 0, 0);
      tbl[5]  = mk(0, 'h0A8,  1, 0, 0,  0,  0,  'h0A7, 'h0A6, 'h0A5, 7,  0, 0, 0);
      // stall M for one cycle: W takes a bubble, nothing lost
      tbl[6]  = mk(0, 'h0A9,  1, 0, 0,  2,  0,  'h0A8, 'h0A7, 'h0A6, 7,  1, 0, 0);
      tbl[7]  = mk(0, 'h0A9,  1, 0, 0,  0,  0,  'h0A8, 'h0A7, 'h000, 3,  0, 0, 0);
      tbl[8]  = mk(0, 'h0AA,  1, 0, 0,  0,  0,  'h0A9, 'h0A8, 'h0A7, 7,  0, 0, 0);
      tbl[9]  = mk(0, 'h000,  0, 0, 0,  0,  0,  'h0AA, 'h0A9, 'h0A8, 7,  0, 0, 0);
      // flush and stall on E together
      tbl[10] = mk(0, 'h1FF,  1, 0, 0,  0,  0,  'h000, 'h0AA, 'h0A9, 6,  0, 0, 0);
      tbl[11] = mk(0, 'h0B0,  1, 0, 0,  1,  1,  'h1FF, 'h000, 'h0AA, 5,  1, 0, 0);
      tbl[12] = mk(0, 'h0B0,  1, 0, 0,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[13] = mk(0, 'h000,  0, 0, 0,  0,  0,  'h0B0, 'h000, 'h000, 1,  0, 0, 0);
      tbl[14] = mk(0, 'h000,  0, 0, 0,  0,  0,  'h000, 'h0B0, 'h000, 2,  0, 0, 0);
      tbl[15] = mk(0, 'h000,  0, 0, 0,  0,  0,  'h000, 'h000, 'h0B0, 4,  0, 0, 0);
      // multi-cycle length 4
      tbl[16] = mk(0, 'h0C1,  1, 1, 4,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[17] = mk(0, 'h0C2,  1, 0, 0,  0,  0,  'h0C1, 'h000, 'h000, 1,  1, 1, 0);
      tbl[18] = mk(0, 'h0C2,  1, 0, 0,  0,  0,  'h0C1, 'h000, 'h000, 1,  1, 1, 0);
      tbl[19] = mk(0, 'h0C2,  1, 0, 0,  0,  0,  'h0C1, 'h000, 'h000, 1,  1, 1, 0);
      tbl[20] = mk(0, 'h0C2,  1, 0, 0,  0,  0,  'h0C1, 'h000, 'h000, 1,  0, 1, 1);
      // degenerate lengths 1 and 0
      tbl[21] = mk(0, 'h0D1,  1, 1, 1,  0,  0,  'h0C2, 'h0C1, 'h000, 3,  0, 0, 0);
      tbl[22] = mk(0, 'h0D2,  1, 1, 0,  0,  0,  'h0D1, 'h0C2, 'h0C1, 7,  0, 0, 0);
      tbl[23] = mk(0, 'h000,  0, 0, 0,  0,  0,  'h0D2, 'h0D1, 'h0C2, 7,  0, 0, 0);
      // length 10 aborted by flush on the 3rd busy cycle
      tbl[24] = mk(0, 'h0E1,  1, 1, 10, 0,  0,  'h000, 'h0D2, 'h0D1, 6,  0, 0, 0);
      tbl[25] = mk(0, 'h0E2,  1, 0, 0,  0,  0,  'h0E1, 'h000, 'h0D2, 5,  1, 1, 0);
      tbl[26] = mk(0, 'h0E2,  1, 0, 0,  0,  0,  'h0E1, 'h000, 'h000, 1,  1, 1, 0);
      tbl[27] = mk(0, 'h0E2,  1, 0, 0,  0,  1,  'h0E1, 'h000, 'h000, 1,  1, 1, 0);
      tbl[28] = mk(0, 'h0E2,  1, 0, 0,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      tbl[29] = mk(0, 'h000,  0, 0, 0,  0,  0,  'h0E2, 'h000, 'h000, 1,  0, 0, 0);

      // reset mid multi-cycle, back-to-back length-2 ops, downstream stall outlasting the count
      seq[0]  = mk(0, 'h101,  1, 1, 5,  0,  0,  'h000, 'h0E2, 'h000, 2,  0, 0, 0);
      seq[1]  = mk(1, 'h102,  1, 1, 3,  0,  0,  'h101, 'h000, 'h0E2, 5,  1, 1, 0);
      seq[2]  = mk(0, 'h111,  1, 1, 2,  0,  0,  'h000, 'h000, 'h000, 0,  0, 0, 0);
      seq[3]  = mk(0, 'h112,  1, 1, 2,  0,  0,  'h111, 'h000, 'h000, 1,  1, 1, 0);
      seq[4]  = mk(0, 'h112,  1, 1, 2,  0,  0,  'h111, 'h000, 'h000, 1,  0, 1, 1);
      seq[5]  = mk(0, 'h113,  1, 0, 0,  4,  0,  'h112, 'h111, 'h000, 3,  1, 1, 0);
      seq[6]  = mk(0, 'h113,  1, 0, 0,  4,  0,  'h112, 'h111, 'h000, 3,  1, 1, 1);
      seq[7]  = mk(0, 'h113,  1, 0, 0,  4,  0,  'h112, 'h111, 'h000, 3,  1, 0, 0);
      seq[8]  = mk(0, 'h113,  1, 0, 0,  0,  0,  'h112, 'h111, 'h000, 3,  0, 0, 0);
      seq[9]  = mk(0, 'h000,  0, 0, 0,  0,  0,  'h113, 'h112, 'h111, 7,  0, 0, 0);

      rst = 1'b1; ctrlD = '0; validD = 1'b0; mcD = 1'b0; mclenD = '0;
      stall = '0; flush = '0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 30; i++) begin
         run_row($sformatf("row%0d", i), tbl[i]);
      end
      for (int i = 0; i < 10; i++) begin
         run_row($sformatf("seq%0d", i), seq[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
